// File: rtl/matmul_ctrl.sv
// Job sequencer for the matmul memory bank. It buffers the host's W and X elements,
// replays them to the bank without gaps, and waits for the bank's unload-complete flag.
module matmul_ctrl #(
  parameter int DW   = 4,
  parameter int MAXE = 9,
  parameter int TMO  = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    cfg_row_w,
  input  logic [1:0]    cfg_col_w,
  input  logic [1:0]    cfg_row_x,
  input  logic [1:0]    cfg_col_x,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          bank_clear_mem,
  output logic          bank_load,
  output logic [DW-1:0] bank_data_in,
  output logic [1:0]    bank_row_w,
  output logic [1:0]    bank_col_w,
  output logic [1:0]    bank_row_x,
  output logic [1:0]    bank_col_x,
  input  logic          bank_unload_res,
  output logic          busy,
  output logic          done,
  output logic          err_dim,
  output logic          err_tmo,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_LOAD    = 3'd2,
    S_STREAM  = 3'd3,
    S_COMPUTE = 3'd4,
    S_FINISH  = 3'd5
  } state_t;

  localparam logic [4:0] TC_LAST = 5'(TMO - 1);

  state_t        r_state, w_state_nx;
  logic [4:0]    r_wp, w_wp_nx;
  logic [4:0]    r_rp, w_rp_nx;
  logic [4:0]    r_tc, w_tc_nx;
  logic [4:0]    r_ntot, w_ntot_nx;
  logic [7:0]    r_dims, w_dims_nx;
  logic [DW-1:0] r_data, w_data_nx;
  logic          r_ready, w_ready_nx;
  logic          r_clear, w_clear_nx;
  logic          r_load, w_load_nx;
  logic          r_busy, w_busy_nx;
  logic          r_done, w_done_nx;
  logic          r_err_dim, w_err_dim_nx;
  logic          r_err_tmo, w_err_tmo_nx;
  logic          w_wr_en;
  logic          w_cfg_ok;
  logic [3:0]    w_nw, w_nx;
  logic [4:0]    w_ntot;
  logic [DW-1:0] r_buf [2*MAXE];

  assign w_nw     = {2'b00, cfg_row_w} * {2'b00, cfg_col_w};
  assign w_nx     = {2'b00, cfg_row_x} * {2'b00, cfg_col_x};
  assign w_ntot   = {1'b0, w_nw} + {1'b0, w_nx};
  assign w_cfg_ok = (cfg_row_w != 2'd0) && (cfg_col_w != 2'd0) &&
                    (cfg_row_x != 2'd0) && (cfg_col_x != 2'd0) &&
                    (cfg_col_w == cfg_row_x);

  // Host handshake: an element transfers on a rising edge where in_valid && in_ready;
  // the host holds in_data stable while in_valid is high and in_ready is low.
  always_comb begin
    w_state_nx   = r_state;
    w_wp_nx      = r_wp;
    w_rp_nx      = r_rp;
    w_tc_nx      = r_tc;
    w_ntot_nx    = r_ntot;
    w_dims_nx    = r_dims;
    w_data_nx    = r_data;
    w_ready_nx   = 1'b0;
    w_clear_nx   = 1'b0;
    w_load_nx    = 1'b0;
    w_done_nx    = 1'b0;
    w_err_dim_nx = 1'b0;
    w_err_tmo_nx = 1'b0;
    w_wr_en      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_cfg_ok) begin
            w_state_nx = S_CLEAR;
            w_dims_nx  = {cfg_row_w, cfg_col_w, cfg_row_x, cfg_col_x};
            w_ntot_nx  = w_ntot;
            w_clear_nx = 1'b1;
          end else begin
            w_err_dim_nx = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        w_wp_nx    = 5'd0;
        w_rp_nx    = 5'd0;
        w_ready_nx = 1'b1;
        w_state_nx = S_LOAD;
      end
      S_LOAD: begin
        w_ready_nx = 1'b1;
        if (in_valid && r_ready) begin
          w_wr_en = 1'b1;
          w_wp_nx = r_wp + 5'd1;
          // Last element accepted: first bank element goes out on the next cycle.
          if (r_wp == r_ntot - 5'd1) begin
            w_state_nx = S_STREAM;
            w_ready_nx = 1'b0;
            w_load_nx  = 1'b1;
            w_data_nx  = r_buf[0];
            w_rp_nx    = 5'd1;
          end
        end
      end
      S_STREAM: begin
        if (r_rp == r_ntot) begin
          w_state_nx = S_COMPUTE;
          w_tc_nx    = 5'd0;
        end else begin
          w_load_nx = 1'b1;
          w_data_nx = r_buf[r_rp];
          w_rp_nx   = r_rp + 5'd1;
        end
      end
      S_COMPUTE: begin
        if (bank_unload_res) begin
          w_state_nx = S_FINISH;
          w_done_nx  = 1'b1;
        end else if (r_tc == TC_LAST) begin
          w_state_nx   = S_FINISH;
          w_err_tmo_nx = 1'b1;
        end else begin
          w_tc_nx = r_tc + 5'd1;
        end
      end
      S_FINISH: w_state_nx = S_IDLE;
      default:  w_state_nx = S_IDLE;
    endcase
    w_busy_nx = (w_state_nx != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_wp      <= 5'd0;
      r_rp      <= 5'd0;
      r_tc      <= 5'd0;
      r_ntot    <= 5'd0;
      r_dims    <= 8'd0;
      r_data    <= '0;
      r_ready   <= 1'b0;
      r_clear   <= 1'b0;
      r_load    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err_dim <= 1'b0;
      r_err_tmo <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_wp      <= w_wp_nx;
      r_rp      <= w_rp_nx;
      r_tc      <= w_tc_nx;
      r_ntot    <= w_ntot_nx;
      r_dims    <= w_dims_nx;
      r_data    <= w_data_nx;
      r_ready   <= w_ready_nx;
      r_clear   <= w_clear_nx;
      r_load    <= w_load_nx;
      r_busy    <= w_busy_nx;
      r_done    <= w_done_nx;
      r_err_dim <= w_err_dim_nx;
      r_err_tmo <= w_err_tmo_nx;
    end
  end

  // Buffer contents are only meaningful after a completed LOAD, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_buf[r_wp] <= in_data;
  end

  assign in_ready       = r_ready;
  assign bank_clear_mem = r_clear;
  assign bank_load      = r_load;
  assign bank_data_in   = r_data;
  assign bank_row_w     = r_dims[7:6];
  assign bank_col_w     = r_dims[5:4];
  assign bank_row_x     = r_dims[3:2];
  assign bank_col_x     = r_dims[1:0];
  assign busy           = r_busy;
  assign done           = r_done;
  assign err_dim        = r_err_dim;
  assign err_tmo        = r_err_tmo;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_matmul_ctrl.sv
// Directed bench for matmul_ctrl: drivers push expected bank traffic and pulses into
// queues, and a negedge monitor pops and compares whenever the DUT presents them.
module tb_matmul_ctrl;
  localparam int DW   = 4;
  localparam int MAXE = 9;
  localparam int TMO  = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    cfg_row_w = '0, cfg_col_w = '0, cfg_row_x = '0, cfg_col_x = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          bank_unload_res = 1'b0;
  logic          in_ready, bank_clear_mem, bank_load;
  logic [DW-1:0] bank_data_in;
  logic [1:0]    bank_row_w, bank_col_w, bank_row_x, bank_col_x;
  logic          busy, done, err_dim, err_tmo;
  logic [2:0]    dbg_state;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int t0 = 0;
  logic [7:0] last_dims = 8'd0;

  logic [DW-1:0] exp_q[$];
  int            exp_clr_q[$];
  int            exp_sst_q[$];
  int            exp_len_q[$];
  logic [2:0]    exp_evt_q[$];
  int            exp_evt_cyc_q[$];
  logic [DW-1:0] elems [2*MAXE];

  matmul_ctrl #(.DW(DW), .MAXE(MAXE), .TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_row_w(cfg_row_w), .cfg_col_w(cfg_col_w), .cfg_row_x(cfg_row_x), .cfg_col_x(cfg_col_x),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .bank_clear_mem(bank_clear_mem), .bank_load(bank_load), .bank_data_in(bank_data_in),
    .bank_row_w(bank_row_w), .bank_col_w(bank_col_w), .bank_row_x(bank_row_x), .bank_col_x(bank_col_x),
    .bank_unload_res(bank_unload_res), .busy(busy), .done(done), .err_dim(err_dim),
    .err_tmo(err_tmo), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int out_vec();
    return int'({busy, done, err_dim, err_tmo, in_ready, bank_load, bank_clear_mem, bank_data_in,
                 bank_row_w, bank_col_w, bank_row_x, bank_col_x, dbg_state});
  endfunction

  function automatic int dims_now();
    return int'({bank_row_w, bank_col_w, bank_row_x, bank_col_x});
  endfunction

  // ---------------- scoreboard monitor ----------------
  logic prev_load = 1'b0;
  int   run_len = 0;
  always @(negedge clk) begin
    int e;
    logic [2:0] obs, ek;
    if (bank_clear_mem) begin
      e = (exp_clr_q.size() != 0) ? exp_clr_q.pop_front() : -1;
      chk("clear_cycle", cyc, e);
    end
    if (bank_load) begin
      if (!prev_load) begin
        e = (exp_sst_q.size() != 0) ? exp_sst_q.pop_front() : -1;
        chk("stream_start", cyc, e);
      end
      e = (exp_q.size() != 0) ? int'(exp_q.pop_front()) : -1;
      chk("stream_data", int'(bank_data_in), e);
      run_len++;
    end else if (prev_load) begin
      e = (exp_len_q.size() != 0) ? exp_len_q.pop_front() : -1;
      chk("stream_len", run_len, e);
      run_len = 0;
    end
    prev_load = bank_load;
    if (done || err_dim || err_tmo) begin
      obs = {err_tmo, err_dim, done};
      ek  = (exp_evt_q.size() != 0) ? exp_evt_q.pop_front() : 3'b000;
      e   = (exp_evt_cyc_q.size() != 0) ? exp_evt_cyc_q.pop_front() : -1;
      chk("pulse_kind", int'(obs), int'(ek));
      chk("pulse_cycle", cyc, e);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue_start(input logic [1:0] rw, cw, rx, cx);
    @(negedge clk);
    t0 = cyc;
    cfg_row_w = rw; cfg_col_w = cw; cfg_row_x = rx; cfg_col_x = cx;
    start = 1'b1;
  endtask

  task automatic wait_until(input int target);
    int g = 0;
    while (cyc < target && g < 1000) begin
      @(negedge clk);
      g++;
    end
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("idle_reached", int'(busy), 0);
  endtask

  // Called on the negedge of cycle 1; returns on the negedge after the last handshake.
  task automatic feed(input int n, input bit gap, input bit disturb, output int last_c);
    int idx = 0, guard = 0, rdy_err = 0;
    bit want_gap, hs;
    want_gap = gap;
    last_c = -1;
    while (idx < n && guard < 200) begin
      int c;
      c = cyc - t0;
      start = disturb && (idx == 2);
      if (want_gap) in_valid = 1'b0;
      else begin
        in_valid = 1'b1;
        in_data  = elems[idx];
      end
      if (in_ready != (c >= 2)) rdy_err++;
      hs = in_valid && in_ready;
      if (want_gap && in_ready) want_gap = 1'b0;
      @(negedge clk);
      guard++;
      if (hs) begin
        last_c = c;
        idx++;
        want_gap = gap;
      end
    end
    start = 1'b0;
    in_valid = 1'b0;
    chk("feed_count", idx, n);
    chk("in_ready_load", rdy_err, 0);
    chk("in_ready_drop", int'(in_ready), 0);
  endtask

  // k: COMPUTE cycle on which the bank raises unload_res; negative means never.
  task automatic run_job(input logic [1:0] rw, cw, rx, cx, input int n, input bit gap,
                         input int exp_load, input int k, input bit disturb);
    int ld, e, last_c;
    ld = 1 + exp_load;
    issue_start(rw, cw, rx, cx);
    exp_clr_q.push_back(t0 + 1);
    exp_sst_q.push_back(t0 + ld + 1);
    exp_len_q.push_back(n);
    for (int i = 0; i < n; i++) exp_q.push_back(elems[i]);
    e = t0 + ld + 1 + n;
    if (k >= 0 && k < TMO) begin
      exp_evt_q.push_back(3'b001); exp_evt_cyc_q.push_back(e + k + 1);
    end else begin
      exp_evt_q.push_back(3'b100); exp_evt_cyc_q.push_back(e + TMO);
    end
    @(negedge clk);
    chk("busy_cycle1", int'(busy), 1);
    chk("dims_latched", dims_now(), int'({rw, cw, rx, cx}));
    last_dims = {rw, cw, rx, cx};
    feed(n, gap, disturb, last_c);
    chk("load_cycles", last_c - 1, exp_load);
    if (disturb) begin
      wait_until(e);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    if (k >= 0) begin
      wait_until(e + k);
      bank_unload_res = 1'b1;
      @(negedge clk);
      bank_unload_res = 1'b0;
    end
    wait_idle();
    chk("dims_held", dims_now(), int'(last_dims));
  endtask

  task automatic bad_start(input logic [1:0] rw, cw, rx, cx);
    issue_start(rw, cw, rx, cx);
    exp_evt_q.push_back(3'b010);
    exp_evt_cyc_q.push_back(t0 + 1);
    @(negedge clk);
    start = 1'b0;
    chk("bad_busy1", int'(busy), 0);
    @(negedge clk);
    chk("bad_busy2", int'(busy), 0);
    chk("bad_dims_held", dims_now(), int'(last_dims));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int rdy_seen;
    repeat (3) @(negedge clk);
    chk("reset_outputs", out_vec(), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 2x2 * 2x2, W=1..4, X=5..8, bank answers on COMPUTE cycle 4 -> done at start+23
    for (int i = 0; i < 8; i++) elems[i] = 4'(i + 1);
    run_job(2'd2, 2'd2, 2'd2, 2'd2, 8, 1'b0, 8, 4, 1'b0);

    // 3x3 * 3x3 with gap-first toggling valid: 36 LOAD cycles; unload already high at entry
    for (int i = 0; i < 18; i++) elems[i] = 4'((i * 7 + 3) % 16);
    run_job(2'd3, 2'd3, 2'd3, 2'd3, 18, 1'b1, 36, 0, 1'b0);

    // rejected configurations
    bad_start(2'd2, 2'd2, 2'd3, 2'd1);
    bad_start(2'd0, 2'd2, 2'd2, 2'd2);
    bad_start(2'd2, 2'd2, 2'd2, 2'd0);

    // 1x3 * 3x1 with the bank silent: err_tmo TMO cycles after COMPUTE entry
    for (int i = 0; i < 6; i++) elems[i] = 4'(15 - i);
    run_job(2'd1, 2'd3, 2'd3, 2'd1, 6, 1'b0, 6, -1, 1'b0);

    // unload on the very cycle tc reaches TMO-1: done, not timeout
    elems[0] = 4'hA; elems[1] = 4'h5;
    run_job(2'd1, 2'd1, 2'd1, 2'd1, 2, 1'b0, 2, TMO - 1, 1'b0);

    // reset asserted after three STREAM elements
    for (int i = 0; i < 8; i++) elems[i] = 4'(9 + i);
    begin
      int lc;
      issue_start(2'd2, 2'd2, 2'd2, 2'd2);
      exp_clr_q.push_back(t0 + 1);
      exp_sst_q.push_back(t0 + 10);
      exp_len_q.push_back(3);
      for (int i = 0; i < 3; i++) exp_q.push_back(elems[i]);
      @(negedge clk);
      feed(8, 1'b0, 1'b0, lc);
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk("rst_async_outputs", out_vec(), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      last_dims = 8'd0;
      @(negedge clk);
    end
    // clean 1x2 * 2x2 job after the reset
    for (int i = 0; i < 6; i++) elems[i] = 4'(i * 3 + 1);
    run_job(2'd1, 2'd2, 2'd2, 2'd2, 6, 1'b0, 6, 2, 1'b0);

    // in_valid held in IDLE, start pulsed in LOAD and COMPUTE: all ignored
    in_valid = 1'b1;
    in_data  = 4'hF;
    rdy_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (in_ready) rdy_seen++;
    end
    chk("in_ready_idle", rdy_seen, 0);
    for (int i = 0; i < 9; i++) elems[i] = 4'(i + 6);
    run_job(2'd2, 2'd3, 2'd3, 2'd1, 9, 1'b0, 9, 4, 1'b1);

    repeat (3) @(negedge clk);
    chk("queues_drained", exp_q.size() + exp_clr_q.size() + exp_sst_q.size() +
        exp_len_q.size() + exp_evt_q.size() + exp_evt_cyc_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/matmul_ctrl.md
# matmul_ctrl

Sequencer for the matrix-multiply memory bank and MAC array. It takes a matrix-size configuration and a gappy host element stream, buffers the W and X elements locally, and replays them to the bank back-to-back at one element per clock. It then waits for the bank's unload-complete flag and reports done, or reports a timeout. It sits between the host/testbench interface and the memory bank, and it is the only driver of the bank's data, clear and dimension inputs.

## Interface
- DW, 4, element width in bits
- MAXE, 9, maximum elements per matrix (3x3)
- TMO, 32, cycles allowed in COMPUTE before timeout

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to begin a job; sampled only in IDLE
- cfg_row_w, cfg_col_w, cfg_row_x, cfg_col_x  input  2 each  matrix dimensions; sampled on accepted start
- in_valid  input  1  host element valid
- in_data  input  DW  host element, row-major; all of W, then all of X
- in_ready  output  1  element accepted when in_valid && in_ready
- bank_clear_mem  output  1  clear strobe to the bank
- bank_load  output  1  high while bank_data_in carries a valid element
- bank_data_in  output  DW  element to the bank
- bank_row_w, bank_col_w, bank_row_x, bank_col_x  output  2 each  latched dimensions
- bank_unload_res  input  1  bank reports all results unloaded
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse on successful completion
- err_dim  output  1  one-cycle pulse when start is rejected
- err_tmo  output  1  one-cycle pulse on COMPUTE timeout

## Operation
- States: IDLE, CLEAR, LOAD, STREAM, COMPUTE, FINISH.
- IDLE, start=1:
  - Reject if any cfg dimension is 0 or cfg_col_w != cfg_row_x. Pulse err_dim next cycle and stay in IDLE.
  - Otherwise latch dims into bank_* and compute nw = row_w*col_w and nx = row_x*col_x, each 4-bit and at most 9. Go to CLEAR.
- CLEAR: bank_clear_mem=1 for exactly 1 cycle. Reset buffer write pointer wp and read pointer rp to 0. Go to LOAD.
- LOAD:
  - in_ready=1.
  - Each handshake writes in_data to buf[wp] and increments wp. buf is 2*MAXE x DW.
  - When the handshake with wp == nw+nx-1 occurs, go to STREAM. in_ready drops the following cycle.
  - Gaps (in_valid=0) are allowed and do not change state.
- STREAM:
  - bank_load=1 and bank_data_in=buf[rp] every cycle. rp increments each cycle.
  - Exactly nw+nx consecutive cycles with no gaps. W elements go first, then X.
  - After the last element, go to COMPUTE.
- COMPUTE: a 5-bit counter tc runs from 0.
  - bank_unload_res=1 → FINISH, done pulse.
  - tc == TMO-1 without bank_unload_res → FINISH, err_tmo pulse.
- FINISH: 1 cycle with the pulse asserted, then IDLE. Latched bank_* dims hold until the next accepted start.
- In_valid outside LOAD is ignored and in_ready=0. Start outside IDLE is ignored.
- Arithmetic: the pointer and element counters are 5-bit, with nw+nx at most 18. There is no wrap-around; the pointers saturate because the FSM leaves LOAD and STREAM exactly at the count.

## Timing
- Reset values: busy, done, err_dim, err_tmo, in_ready, bank_load and bank_clear_mem are 0. bank_data_in and all bank_* dims are 0. State is IDLE.
- Reset asserted mid-job returns the block to IDLE immediately, with all outputs at their reset values and buffer contents discarded.
- All outputs are registered. Every pulse is exactly 1 cycle wide.
- Cycle counts from the accepted start edge:
  - CLEAR at cycle 1.
  - LOAD from cycle 2.
  - With zero-gap input, STREAM starts at cycle 2+nw+nx and lasts nw+nx cycles.
  - COMPUTE follows.
- Minimum latency to done is 3 + 2(nw+nx) + k cycles after start, where k is the number of cycles until bank_unload_res is seen.
- bank_unload_res is sampled only in COMPUTE. If it is already high on the first COMPUTE cycle, done fires the next cycle.
- If bank_unload_res arrives on the same cycle tc reaches TMO-1, done wins and err_tmo stays 0.

## Test plan
- 2x2 by 2x2, W={1,2,3,4}, X={5,6,7,8}, no gaps. Expected:
  - bank_clear_mem for 1 cycle.
  - bank_data_in = 1,2,3,4,5,6,7,8 on 8 consecutive bank_load cycles.
  - Bank model raises unload_res 4 cycles later, so done at cycle 3+16+4.
- 3x3 by 3x3 with in_valid toggling every other cycle. Expected:
  - LOAD takes 36 cycles.
  - STREAM is 18 gapless cycles in input order.
  - Dims latched as 3.
- start with cfg_col_w=2, cfg_row_x=3 → err_dim pulse, busy stays 0, no bank_clear_mem. Same result for cfg_row_w=0.
- 1x3 by 3x1, bank_unload_res never asserted → err_tmo exactly TMO cycles after COMPUTE entry, done=0, then IDLE.
- rst_n low mid-STREAM after 3 elements → all outputs 0 asynchronously. A new start after release runs a full clean job.
- start pulsed during LOAD and COMPUTE, and in_valid held high in IDLE → both ignored, in_ready=0 outside LOAD, job completes normally.
